uart_tx_cfg: RTL and testbench



---
 rtl/uart_tx_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Purpose: parametrised UART transmitter with integrated baud divider (start, LSB-first data, optional parity, 1/2 stop bits).
// Latency: start bit drives tx on the edge after accept; frame is BAUD_COUNT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) clocks to tx_done.
// Backpressure: tx_ready is low for the whole frame; it rises with tx_done so a held tx_valid streams frames with a one-clock idle gap.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-low reset (aborts any frame, no tx_done)
//   tx_data  word to send, sampled only when tx_valid && tx_ready
//   tx_valid source has a word
//   tx_ready block can accept a word (registered)
//   tx_busy  frame in progress (registered)
//   tx_done  one-cycle pulse entering IDLE after the final stop bit (registered)
//   tx       serial line, idle high (registered)
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
    // Guard keeps the width sane long enough for the elaboration error below to fire.
    localparam int BAUD_W = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_COUNT - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (BAUD_COUNT < 2) begin : g_bad_baud
        $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;
    logic                  baud_last;
    logic                  par_next;

    assign baud_last = (baud_cnt == BAUD_LAST);
    // Parity is taken from the word as it is latched, so later tx_data changes cannot affect it.
    assign par_next  = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // The divider free-runs while a frame is active and wraps at every bit boundary.
            if (state != S_IDLE) begin
                baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
            end

            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        par_bit  <= par_next;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end

                S_PARITY: begin
                    if (baud_last) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (baud_last) begin
                        if (bit_cnt == STOP_LAST) begin
                            // Ready rises with done so a waiting word is taken on the very next edge.
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Purpose: self-checking bench for uart_tx_cfg (8N1, 7E2 and 7O2 instances at BAUD_COUNT=10).
// Latency: expected frames are queued at drive time and popped by a line monitor on dut_a.
// Backpressure: exercises held tx_valid, ignored tx_valid while busy, and reset mid-frame.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, busy_a, done_a, tx_a;
    logic [6:0] data_bc;
    logic       valid_bc;
    logic       ready_b, busy_b, done_b, tx_b;
    logic       ready_c, busy_c, done_c, tx_c;

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(data_bc), .tx_valid(valid_bc),
        .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .tx_data(data_bc), .tx_valid(valid_bc),
        .tx_ready(ready_c), .tx_busy(busy_c), .tx_done(done_c), .tx(tx_c));

    int checks = 0;
    int passed = 0;
    int frames_seen = 0;
    logic [9:0] sb_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    endtask

    // Line monitor for dut_a: frame word bit i is the i-th bit on the wire (start first).
    initial begin : mon_a
        logic [9:0] bits;
        logic [9:0] exp_f;
        bit stable;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_a === 1'b0) begin
                bits = '0; stable = 1'b1; ab = 1'b0;
                for (int i = 0; i < 10 && !ab; i++) begin
                    for (int c = 0; c < 10 && !ab; c++) begin
                        if (i != 0 || c != 0) @(negedge clk);
                        if (rst !== 1'b1) ab = 1'b1;
                        else if (c == 0) bits[i] = tx_a;
                        else if (tx_a !== bits[i]) stable = 1'b0;
                    end
                end
                if (!ab) begin
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_frame: got frame 0x%0h, required no frame", bits);
                    end else begin
                        exp_f = sb_q.pop_front();
                        check("frame_bits", int'(bits), int'(exp_f));
                        check("bit_width_10clk", int'(stable), 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    // Watch dut_a for 130 clocks starting at the negedge after the accept edge.
    task automatic watch_a(input bit noise, output int done_e, output int rl, output int dones);
        done_e = -1; rl = 0; dones = 0;
        for (int e = 0; e < 130; e++) begin
            if (!ready_a) rl++;
            if (done_a) begin
                dones++;
                if (done_e < 0) done_e = e;
            end
            if (noise && e >= 20 && e < 60) begin
                data_a  = 8'($urandom);
                valid_a = e[0];
            end else begin
                valid_a = 1'b0;
            end
            @(negedge clk);
        end
        valid_a = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        bit         noise;
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        int done_e, rl, dones, e, db, dc;
        logic [10:0] bits_b, bits_c;

        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h81, 10'h302, 1'b1};
        vecs[4] = '{8'hA5, 10'h34A, 1'b1};

        rst = 1'b0; data_a = '0; valid_a = 1'b0; data_bc = '0; valid_bc = 1'b0;

        // Reset and idle outputs: {tx, ready, busy, done}
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("reset_outputs", int'({tx_a, ready_a, busy_a, done_a}), 4'b1100);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_outputs", int'({tx_a, ready_a, busy_a, done_a}), 4'b1100);
        end

        // Table-driven single frames, some with tx_data/tx_valid noise mid-frame.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            data_a = vecs[v].data; valid_a = 1'b1;
            sb_q.push_back(vecs[v].frame);
            @(negedge clk);
            valid_a = 1'b0;
            watch_a(vecs[v].noise, done_e, rl, dones);
            check("frame_len_8n1", done_e, 100);
            check("ready_low_clks", rl, 100);
            check("done_pulses", dones, 1);
        end

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        data_a = 8'hA5; valid_a = 1'b1;
        sb_q.push_back(10'h34A);
        @(negedge clk);
        data_a = 8'h3C;
        sb_q.push_back(10'h278);
        check("b2b_ready_low", int'(ready_a), 0);
        e = 0;
        while (!done_a && e < 200) begin @(negedge clk); e++; end
        check("b2b_first_len", e, 100);
        check("b2b_gap_idle_high", int'({tx_a, ready_a}), 2'b11);
        @(negedge clk);
        check("b2b_second_start", int'({tx_a, ready_a, busy_a}), 3'b001);
        valid_a = 1'b0;
        e = 0;
        while (!done_a && e < 200) begin @(negedge clk); e++; end
        check("b2b_second_len", e, 100);

        // Reset during data bit 3 of 0xFF, then immediate re-accept.
        repeat (3) @(negedge clk);
        data_a = 8'hFF; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (44) @(negedge clk);
        check("mid_frame_busy", int'(busy_a), 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_outputs", int'({tx_a, ready_a, busy_a, done_a}), 4'b1100);
        @(negedge clk);
        check("rst_no_done", int'(done_a), 0);
        rst = 1'b1; data_a = 8'h81; valid_a = 1'b1;
        sb_q.push_back(10'h302);
        @(negedge clk);
        valid_a = 1'b0;
        check("rst_reaccept", int'({ready_a, busy_a, tx_a}), 3'b010);
        watch_a(1'b0, done_e, rl, dones);
        check("rst_reaccept_len", done_e, 100);
        check("rst_done_pulses", dones, 1);

        // 7E2 and 7O2 with word 0x13, sampled mid-bit.
        @(negedge clk);
        data_bc = 7'h13; valid_bc = 1'b1;
        @(negedge clk);
        valid_bc = 1'b0;
        bits_b = '0; bits_c = '0; db = -1; dc = -1;
        for (int k = 0; k < 140; k++) begin
            if (k % 10 == 5 && k / 10 < 11) begin
                bits_b[k / 10] = tx_b;
                bits_c[k / 10] = tx_c;
            end
            if (done_b && db < 0) db = k;
            if (done_c && dc < 0) dc = k;
            @(negedge clk);
        end
        check("line_7e2", int'(bits_b), 11'h726);
        check("line_7o2", int'(bits_c), 11'h626);
        check("frame_len_7e2", db, 110);
        check("frame_len_7o2", dc, 110);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        check("frames_seen", frames_seen, 8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
